trap_arbiter: RTL and testbench

Multi-hart machine-mode trap controller for the barrel pipeline. It arbitrates synchronous exceptions and the three standard machine interrupts (software, timer, external) per hart, and tracks which harts are inside a handler. It supports direct and vectored `mtvec` modes, and emits one registered trap-entry command per cycle to the commit stage and CSR file. It replaces the hart0-only, external-interrupt-only combinational trap decision.

---
 rtl/trap_arbiter_if.sv | 49 ++++
 rtl/trap_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_trap_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_arbiter_if.sv
// trap_arbiter_if
//   Commit-slot request bundle and trap-entry command bundle between the
//   barrel pipeline commit stage and the trap arbiter.
//
//   Handshake: there is no ready/backpressure on either side. The commit
//   slot fields are sampled every cycle and are meaningful only while
//   slot_valid=1 (exc_valid and mret_valid are ignored otherwise).
//   trap_valid is a one-cycle registered pulse; the trap_* payload is
//   meaningful while trap_valid=1 and holds its last value otherwise.
//
//   master : commit stage  (drives slot_*, exc_*, mret_valid; reads trap_*)
//   slave  : trap arbiter  (reads slot_*, exc_*, mret_valid; drives trap_*)

`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif

interface trap_arbiter_if #(
   parameter int HART_ID_W = `HART_ID_W,
   parameter int XLEN      = `XLEN
);
   logic                 slot_valid;
   logic [HART_ID_W-1:0] slot_hart_id;
   logic [XLEN-1:0]      slot_pc;
   logic                 exc_valid;
   logic [3:0]           exc_cause;
   logic [XLEN-1:0]      exc_tval;
   logic                 mret_valid;

   logic                 trap_valid;
   logic [HART_ID_W-1:0] trap_hart_id;
   logic [XLEN-1:0]      trap_vector;
   logic [XLEN-1:0]      trap_mepc;
   logic [XLEN-1:0]      trap_mcause;
   logic [XLEN-1:0]      trap_mtval;

   modport master (
      output slot_valid, slot_hart_id, slot_pc, exc_valid, exc_cause, exc_tval, mret_valid,
      input  trap_valid, trap_hart_id, trap_vector, trap_mepc, trap_mcause, trap_mtval
   );

   modport slave (
      input  slot_valid, slot_hart_id, slot_pc, exc_valid, exc_cause, exc_tval, mret_valid,
      output trap_valid, trap_hart_id, trap_vector, trap_mepc, trap_mcause, trap_mtval
   );
endinterface

// File: rtl/trap_arbiter.sv
// trap_arbiter
//   Multi-hart machine-mode trap controller. Samples the three standard
//   machine interrupts per hart, evaluates the commit-slot hart each cycle
//   for an exception or interrupt, and issues one registered trap-entry
//   command. Tracks per-hart handler state (IDLE/HANDLER).
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     mstatus_mie   per-hart mstatus.MIE
//     mie_bits      per-hart {MEIE,MTIE,MSIE}, hart h at [3h+2:3h]
//     mip_bits      per-hart {MEIP,MTIP,MSIP}, same packing
//     mtvec         per-hart mtvec, hart h at [XLEN*h +: XLEN]
//     tif           commit slot in / trap-entry command out (slave side)
//     in_handler    per-hart handler-active flag (exposes the FSM state)

`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif

module trap_arbiter #(
   parameter int                   NUM_HARTS     = 4,
   parameter int                   HART_ID_W     = `HART_ID_W,
   parameter int                   XLEN          = `XLEN,
   parameter logic [NUM_HARTS-1:0] IRQ_HART_MASK = {NUM_HARTS{1'b1}}
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_HARTS-1:0]      mstatus_mie,
   input  logic [3*NUM_HARTS-1:0]    mie_bits,
   input  logic [3*NUM_HARTS-1:0]    mip_bits,
   input  logic [XLEN*NUM_HARTS-1:0] mtvec,
   trap_arbiter_if.slave             tif,
   output logic [NUM_HARTS-1:0]      in_handler
);

   typedef enum logic {
      HART_IDLE    = 1'b0,
      HART_HANDLER = 1'b1
   } hart_state_e;

   localparam logic [3:0] CODE_MSI = 4'd3;
   localparam logic [3:0] CODE_MTI = 4'd7;
   localparam logic [3:0] CODE_MEI = 4'd11;

   // ---------------------------------------------------------------
   // Interrupt sampling: level-sensitive, one cycle of latency.
   // ---------------------------------------------------------------
   logic [NUM_HARTS-1:0] irq_pend_d, irq_pend_q;
   logic [3:0]           irq_code_d [NUM_HARTS];
   logic [3:0]           irq_code_q [NUM_HARTS];

   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         logic [2:0] act;
         act           = mie_bits[3*h +: 3] & mip_bits[3*h +: 3];
         irq_pend_d[h] = IRQ_HART_MASK[h] & mstatus_mie[h] & (|act);
         // MEI > MSI > MTI; act bit order is {E,T,S}
         if (act[2])      irq_code_d[h] = CODE_MEI;
         else if (act[0]) irq_code_d[h] = CODE_MSI;
         else             irq_code_d[h] = CODE_MTI;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_pend_q <= '0;
         for (int h = 0; h < NUM_HARTS; h++) irq_code_q[h] <= '0;
      end else begin
         irq_pend_q <= irq_pend_d;
         for (int h = 0; h < NUM_HARTS; h++) irq_code_q[h] <= irq_code_d[h];
      end
   end

   // ---------------------------------------------------------------
   // Commit-slot hart selection. A hart id outside NUM_HARTS never
   // matches, so such a slot cannot trap or change any state.
   // ---------------------------------------------------------------
   hart_state_e state_q [NUM_HARTS];
   hart_state_e state_d [NUM_HARTS];

   logic            slot_ok;
   logic            sel_pend;
   logic [3:0]      sel_code;
   hart_state_e     sel_state;
   logic [XLEN-1:0] sel_mtvec;

   always_comb begin
      slot_ok   = 1'b0;
      sel_pend  = 1'b0;
      sel_code  = '0;
      sel_state = HART_IDLE;
      sel_mtvec = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (tif.slot_hart_id == HART_ID_W'(h)) begin
            slot_ok   = 1'b1;
            sel_pend  = irq_pend_q[h];
            sel_code  = irq_code_q[h];
            sel_state = state_q[h];
            sel_mtvec = mtvec[XLEN*h +: XLEN];
         end
      end
   end

   // ---------------------------------------------------------------
   // Take decision. Exceptions beat everything (including a same-slot
   // mret); interrupts need IDLE and no mret in the slot, so an mret
   // retiring alongside a pending interrupt defers it to the next slot.
   // ---------------------------------------------------------------
   logic slot_live, take_exc, take_irq, take, do_mret;

   always_comb begin
      slot_live = tif.slot_valid & slot_ok;
      take_exc  = slot_live & tif.exc_valid;
      take_irq  = slot_live & ~tif.exc_valid & sel_pend &
                  (sel_state == HART_IDLE) & ~tif.mret_valid;
      take      = take_exc | take_irq;
      do_mret   = slot_live & tif.mret_valid & ~take;
   end

   // ---------------------------------------------------------------
   // Per-hart handler FSM.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int h = 0; h < NUM_HARTS; h++) state_q[h] <= HART_IDLE;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) state_q[h] <= state_d[h];
      end
   end

   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) begin
         state_d[h] = state_q[h];
         if (tif.slot_hart_id == HART_ID_W'(h)) begin
            if (take)         state_d[h] = HART_HANDLER;
            else if (do_mret) state_d[h] = HART_IDLE;
         end
      end
   end

   always_comb begin
      for (int h = 0; h < NUM_HARTS; h++) in_handler[h] = (state_q[h] == HART_HANDLER);
   end

   // ---------------------------------------------------------------
   // Trap payload. Mode 2'b1x is treated as direct; the vectored sum
   // wraps at XLEN bits.
   // ---------------------------------------------------------------
   logic [XLEN-1:0] base, vec_d, mcause_d, mtval_d;

   always_comb begin
      base = {sel_mtvec[XLEN-1:2], 2'b00};
      if (take_exc) begin
         vec_d    = base;
         mcause_d = {{(XLEN-4){1'b0}}, tif.exc_cause};
         mtval_d  = tif.exc_tval;
      end else begin
         if (sel_mtvec[1:0] == 2'b01) vec_d = base + {{(XLEN-6){1'b0}}, sel_code, 2'b00};
         else                         vec_d = base;
         mcause_d = {1'b1, {(XLEN-5){1'b0}}, sel_code};
         mtval_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tif.trap_valid   <= 1'b0;
         tif.trap_hart_id <= '0;
         tif.trap_vector  <= '0;
         tif.trap_mepc    <= '0;
         tif.trap_mcause  <= '0;
         tif.trap_mtval   <= '0;
      end else begin
         tif.trap_valid <= take;
         if (take) begin
            tif.trap_hart_id <= tif.slot_hart_id;
            tif.trap_vector  <= vec_d;
            tif.trap_mepc    <= tif.slot_pc;
            tif.trap_mcause  <= mcause_d;
            tif.trap_mtval   <= mtval_d;
         end
      end
   end

endmodule

// File: tb/tb_trap_arbiter.sv
module tb_trap_arbiter;
   localparam int NH = 4;
   localparam int W  = 32;
   localparam logic [NH-1:0] MASK = 4'b1110;

   logic            clk;
   logic            rst_n;
   logic [NH-1:0]   mstatus_mie;
   logic [3*NH-1:0] mie_bits;
   logic [3*NH-1:0] mip_bits;
   logic [W*NH-1:0] mtvec;
   logic [NH-1:0]   in_handler;

   trap_arbiter_if #(.HART_ID_W(2), .XLEN(W)) tif ();

   trap_arbiter #(
      .NUM_HARTS(NH), .HART_ID_W(2), .XLEN(W), .IRQ_HART_MASK(MASK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mstatus_mie(mstatus_mie), .mie_bits(mie_bits),
      .mip_bits(mip_bits), .mtvec(mtvec), .tif(tif), .in_handler(in_handler)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   bit          m_hand [NH];
   bit          m_pend [NH];
   int          m_code [NH];
   bit          e_valid;
   logic [1:0]  e_hid;
   logic [W-1:0] e_vec, e_mepc, e_mcause, e_mtval;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   task automatic model_reset();
      for (int h = 0; h < NH; h++) begin
         m_hand[h] = 0; m_pend[h] = 0; m_code[h] = 0;
      end
      e_valid = 0; e_hid = 0; e_vec = 0; e_mepc = 0; e_mcause = 0; e_mtval = 0;
   endtask

   function automatic logic [NH-1:0] exp_hand();
      logic [NH-1:0] v;
      for (int h = 0; h < NH; h++) v[h] = m_hand[h];
      return v;
   endfunction

   task automatic check_all(input string pfx);
      check({pfx, "_valid"},  {31'd0, tif.trap_valid}, {31'd0, e_valid});
      check({pfx, "_hart"},   {30'd0, tif.trap_hart_id}, {30'd0, e_hid});
      check({pfx, "_vector"}, tif.trap_vector, e_vec);
      check({pfx, "_mepc"},   tif.trap_mepc, e_mepc);
      check({pfx, "_mcause"}, tif.trap_mcause, e_mcause);
      check({pfx, "_mtval"},  tif.trap_mtval, e_mtval);
      check({pfx, "_inhand"}, {28'd0, in_handler}, {28'd0, exp_hand()});
   endtask

   // One clock: predict from the spec rules, advance, compare.
   task automatic tick(input string pfx);
      int h;
      bit tk_e, tk_i;
      logic [W-1:0] mt, base;
      // interrupt code -> mip/mie bit index, highest priority first
      int prio_code [3] = '{11, 3, 7};
      int prio_bit  [3] = '{2, 0, 1};
      h = int'(tif.slot_hart_id);
      tk_e = 0; tk_i = 0;
      if (tif.slot_valid) begin
         if (tif.exc_valid) tk_e = 1;
         else if (m_pend[h] && !m_hand[h] && !tif.mret_valid) tk_i = 1;
      end
      mt   = mtvec[W*h +: W];
      base = mt & ~32'd3;
      e_valid = tk_e | tk_i;
      if (tk_e) begin
         e_hid = tif.slot_hart_id; e_mepc = tif.slot_pc; e_vec = base;
         e_mcause = 32'(tif.exc_cause); e_mtval = tif.exc_tval;
         m_hand[h] = 1;
      end else if (tk_i) begin
         e_hid = tif.slot_hart_id; e_mepc = tif.slot_pc;
         e_vec = (mt[1:0] == 2'b01) ? base + 32'(4 * m_code[h]) : base;
         e_mcause = 32'h8000_0000 + 32'(m_code[h]); e_mtval = 0;
         m_hand[h] = 1;
      end else if (tif.slot_valid && tif.mret_valid) begin
         m_hand[h] = 0;
      end
      for (int k = 0; k < NH; k++) begin
         bit found = 0;
         for (int p = 0; p < 3; p++) begin
            if (!found && mie_bits[3*k + prio_bit[p]] && mip_bits[3*k + prio_bit[p]]) begin
               found = 1; m_code[k] = prio_code[p];
            end
         end
         if (!found) m_code[k] = 7;
         m_pend[k] = MASK[k] && mstatus_mie[k] && found;
      end
      @(posedge clk);
      #1;
      check_all(pfx);
   endtask

   // driver helpers
   task automatic set_irq(input int h, input logic [2:0] ie, input logic [2:0] ip);
      mie_bits[3*h +: 3] = ie;
      mip_bits[3*h +: 3] = ip;
   endtask

   task automatic slot(input int h, input logic [W-1:0] pc, input bit exc, input logic [3:0] cause,
                       input logic [W-1:0] tval, input bit mret);
      tif.slot_valid = 1; tif.slot_hart_id = 2'(h); tif.slot_pc = pc;
      tif.exc_valid = exc; tif.exc_cause = cause; tif.exc_tval = tval; tif.mret_valid = mret;
   endtask

   task automatic idle();
      tif.slot_valid = 0; tif.exc_valid = 0; tif.mret_valid = 0;
      tif.slot_hart_id = 2'(3); tif.slot_pc = 0; tif.exc_cause = 0; tif.exc_tval = 0;
   endtask

   initial begin
      rst_n = 0;
      mstatus_mie = '1; mie_bits = '1; mip_bits = '0;
      mtvec = {32'h0000_0500, 32'h0000_0100, 32'h0000_0400, 32'h0000_0300};
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;

      // hart 2 external interrupt, direct mtvec 0x100
      set_irq(2, 3'b111, 3'b100);
      tick("h2_arm");
      slot(2, 32'h2000, 0, 0, 0, 0);
      tick("h2_take");
      check("h2_lit_mcause", tif.trap_mcause, 32'h8000_000B);
      check("h2_lit_vec", tif.trap_vector, 32'h100);
      check("h2_lit_mepc", tif.trap_mepc, 32'h2000);
      set_irq(2, 3'b111, 3'b000);
      slot(2, 32'h2004, 0, 0, 0, 1);
      tick("h2_mret");

      // vectored priority on hart 3
      mtvec[W*3 +: W] = 32'h201;
      set_irq(3, 3'b111, 3'b011);
      idle(); tick("vp_arm");
      slot(3, 32'h3000, 0, 0, 0, 0);
      tick("vp_msi");
      check("vp_lit_mcause", tif.trap_mcause, 32'h8000_0003);
      check("vp_lit_vec", tif.trap_vector, 32'h20C);
      set_irq(3, 3'b111, 3'b010);
      slot(3, 32'h3100, 0, 0, 0, 1);
      tick("vp_mret");
      idle(); tick("vp_gap");
      slot(3, 32'h3200, 0, 0, 0, 0);
      tick("vp_mti");
      check("vp_lit_mcause2", tif.trap_mcause, 32'h8000_0007);
      check("vp_lit_vec2", tif.trap_vector, 32'h21C);
      set_irq(3, 3'b111, 3'b000);
      slot(3, 32'h3204, 0, 0, 0, 1);
      tick("vp_mret2");

      // masked hart 0: interrupt ignored, exception taken
      set_irq(0, 3'b111, 3'b111);
      idle(); tick("mk_arm");
      slot(0, 32'h40, 0, 0, 0, 0);
      tick("mk_noirq");
      slot(0, 32'h40, 1, 4'd2, 32'hDEAD_BEEF, 0);
      tick("mk_exc");
      check("mk_lit_mcause", tif.trap_mcause, 32'h2);
      check("mk_lit_mtval", tif.trap_mtval, 32'hDEAD_BEEF);
      check("mk_lit_vec", tif.trap_vector, 32'h300);
      set_irq(0, 3'b111, 3'b000);
      slot(0, 32'h44, 0, 0, 0, 1);
      tick("mk_mret");

      // hart 1 in-handler blocking and mret + pending in one slot
      set_irq(1, 3'b111, 3'b001);
      idle(); tick("ih_arm");
      slot(1, 32'h1000, 0, 0, 0, 0); tick("ih_take");
      slot(1, 32'h1004, 0, 0, 0, 0); tick("ih_block");
      check("ih_lit_block", {31'd0, tif.trap_valid}, 32'd0);
      slot(1, 32'h1008, 0, 0, 0, 1); tick("ih_mret");
      check("ih_lit_inh", {31'd0, in_handler[1]}, 32'd0);
      check("ih_lit_nomret", {31'd0, tif.trap_valid}, 32'd0);
      slot(1, 32'h100C, 0, 0, 0, 0); tick("ih_retake");
      check("ih_lit_retake", {31'd0, tif.trap_valid}, 32'd1);
      set_irq(1, 3'b111, 3'b000);
      slot(1, 32'h1010, 0, 0, 0, 1); tick("ih_mret2");

      // one-cycle glitch on hart 2, then exception + mret in one slot
      set_irq(2, 3'b111, 3'b001);
      idle(); tick("gl_pulse");
      set_irq(2, 3'b111, 3'b000);
      tick("gl_drop");
      slot(2, 32'h2100, 0, 0, 0, 0); tick("gl_slot");
      check("gl_lit_none", {31'd0, tif.trap_valid}, 32'd0);
      slot(2, 32'h2104, 1, 4'd5, 32'h55, 0); tick("em_enter");
      slot(2, 32'h2108, 1, 4'd7, 32'h77, 1); tick("em_both");
      check("em_lit_inh", {31'd0, in_handler[2]}, 32'd1);
      check("em_lit_mcause", tif.trap_mcause, 32'h7);
      slot(2, 32'h210C, 0, 0, 0, 1); tick("em_mret");

      // randomized phase
      for (int i = 0; i < 400; i++) begin
         mstatus_mie = 4'($urandom_range(0, 15));
         mie_bits    = 12'($urandom_range(0, 4095));
         mip_bits    = 12'($urandom_range(0, 4095));
         if ($urandom_range(0, 15) == 0) begin
            for (int h = 0; h < NH; h++) mtvec[W*h +: W] = $urandom();
         end
         if ($urandom_range(0, 3) == 0) idle();
         else slot($urandom_range(0, NH-1), $urandom(), $urandom_range(0, 4) == 0,
                   4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 2) == 0);
         tick("rnd");
      end

      // asynchronous reset with harts 0 and 2 in handler and a live pulse
      rst_n = 0; idle(); mip_bits = '0;
      #2; rst_n = 1;
      model_reset();
      @(posedge clk); #1;
      slot(0, 32'h10, 1, 4'd1, 32'h1, 0); tick("rs_h0");
      slot(2, 32'h20, 1, 4'd1, 32'h2, 0); tick("rs_h2");
      check("rs_lit_inh", {28'd0, in_handler}, 32'h5);
      check("rs_lit_valid", {31'd0, tif.trap_valid}, 32'd1);
      idle();
      #2; rst_n = 0;
      #1;
      model_reset();
      check_all("rs_async");
      @(negedge clk);
      rst_n = 1;
      tick("rs_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // hard stop in case something stalls the sequence
   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
